xalu_mac: RTL and testbench



---
 rtl/xalu_mac_if.sv | 25 ++
 rtl/xalu_mac.sv | 175 +++++++++++++++++
 tb/tb_xalu_mac.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xalu_mac_if.sv
// Operation/result handshake bundle for the xalu_mac approximate-arithmetic unit.
// master drives requests and result acceptance; slave is the unit itself.
interface xalu_mac_if #(
   parameter int unsigned XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   logic            sat_o;

   modport master (
      output valid_i, op_i, a_i, b_i, ready_i,
      input  ready_o, valid_o, result_o, sat_o
   );

   modport slave (
      input  valid_i, op_i, a_i, b_i, ready_i,
      output ready_o, valid_o, result_o, sat_o
   );
endinterface

// File: rtl/xalu_mac.sv
// Multi-cycle exact/approximate add, multiply and saturating multiply-accumulate
// (X-unit) with an iterative shift-add multiplier and DRUM operand truncation.
module xalu_mac #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned SEG_W  = 4,
   parameter int unsigned DRUM_K = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   xalu_mac_if.slave   bus
);
   localparam int unsigned H    = XLEN / 2;
   localparam int unsigned NSEG = XLEN / SEG_W;
   localparam int unsigned CW   = $clog2(H + 1);
   localparam int unsigned SW   = $clog2(XLEN + 1);

   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_XADD   = 3'd1;
   localparam logic [2:0] OP_MUL    = 3'd2;
   localparam logic [2:0] OP_XMUL   = 3'd3;
   localparam logic [2:0] OP_MAC    = 3'd4;
   localparam logic [2:0] OP_XMAC   = 3'd5;
   localparam logic [2:0] OP_CLRACC = 3'd6;
   localparam logic [2:0] OP_RDACC  = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q;
   logic [XLEN-1:0] mcand_q;
   logic [H-1:0]    mplier_q;
   logic [XLEN-1:0] prod_q;
   logic [CW-1:0]   cnt_q;
   logic [SW-1:0]   shamt_q;
   logic [XLEN-1:0] acc_q;
   logic            sat_q;
   logic [XLEN-1:0] result_q;

   // Segmented adder: each segment's carry-in is speculated from the
   // previous segment alone (its own carry-in assumed zero).
   function automatic logic [XLEN-1:0] xadd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      logic [SEG_W:0]  g;
      logic [SEG_W:0]  s;
      logic            c;
      r = '0;
      c = 1'b0;
      for (int i = 0; i < int'(NSEG); i++) begin
         g = {1'b0, a[i*SEG_W +: SEG_W]} + {1'b0, b[i*SEG_W +: SEG_W]};
         s = g + (SEG_W+1)'(c);
         r[i*SEG_W +: SEG_W] = s[SEG_W-1:0];
         c = g[SEG_W];
      end
      return r;
   endfunction

   // DRUM truncation: keep DRUM_K bits from the leading one, force the LSB.
   function automatic void drum(input logic [H-1:0] x, output logic [H-1:0] xp,
                                output logic [SW-1:0] s);
      int p;
      p  = 0;
      xp = x;
      s  = '0;
      for (int i = 0; i < int'(H); i++) begin
         if (x[i]) p = i;
      end
      if (p >= int'(DRUM_K)) begin
         s  = SW'(p - int'(DRUM_K) + 1);
         xp = (x >> s) | H'(1);
      end
   endfunction

   logic            accept;
   logic            is_mul_op;
   logic            is_approx;
   logic            is_mac;
   logic [H-1:0]    a_x, b_x;
   logic [SW-1:0]   a_s, b_s;
   logic [XLEN-1:0] prod_step;
   logic [XLEN-1:0] prod_full;
   logic [XLEN:0]   acc_sum;

   always_comb begin
      accept    = bus.valid_i && (state_q == S_IDLE);
      is_mul_op = (bus.op_i == OP_MUL) || (bus.op_i == OP_XMUL) ||
                  (bus.op_i == OP_MAC) || (bus.op_i == OP_XMAC);
      is_approx = (bus.op_i == OP_XMUL) || (bus.op_i == OP_XMAC);
      is_mac    = (op_q == OP_MAC) || (op_q == OP_XMAC);
      drum(bus.a_i[H-1:0], a_x, a_s);
      drum(bus.b_i[H-1:0], b_x, b_s);
      prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
      prod_full = prod_step << shamt_q;
      acc_sum   = {1'b0, acc_q} + {1'b0, prod_full};
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.valid_i) state_d = is_mul_op ? S_MUL : S_DONE;
         S_MUL:   if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  if (bus.ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture, shift-add iteration and accumulator update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         shamt_q  <= '0;
         acc_q    <= '0;
         sat_q    <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         op_q   <= bus.op_i;
         prod_q <= '0;
         if (is_approx) begin
            mcand_q  <= XLEN'(a_x);
            mplier_q <= b_x;
            shamt_q  <= a_s + b_s;
            cnt_q    <= CW'(DRUM_K - 1);
         end else begin
            mcand_q  <= XLEN'(bus.a_i[H-1:0]);
            mplier_q <= bus.b_i[H-1:0];
            shamt_q  <= '0;
            cnt_q    <= CW'(H - 1);
         end
         case (bus.op_i)
            OP_ADD:  result_q <= bus.a_i + bus.b_i;
            OP_XADD: result_q <= xadd(bus.a_i, bus.b_i);
            OP_CLRACC: begin
               result_q <= acc_q;
               acc_q    <= '0;
               sat_q    <= 1'b0;
            end
            OP_RDACC: result_q <= acc_q;
            default: ;
         endcase
      end else if (state_q == S_MUL) begin
         prod_q   <= prod_step;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CW'(1);
         if (cnt_q == '0) begin
            if (!is_mac) begin
               result_q <= prod_full;
            end else if (acc_sum[XLEN]) begin
               acc_q    <= '1;
               sat_q    <= 1'b1;
               result_q <= '1;
            end else begin
               acc_q    <= acc_sum[XLEN-1:0];
               result_q <= acc_sum[XLEN-1:0];
            end
         end
      end
   end

   // Reset forces the unit idle immediately, so the handshake reflects it in the same cycle
   assign bus.ready_o  = (state_q == S_IDLE) | rst_i;
   assign bus.valid_o  = (state_q == S_DONE) & ~rst_i;
   assign bus.result_o = result_q;
   assign bus.sat_o    = sat_q;
endmodule

// File: tb/tb_xalu_mac.sv
// Self-checking bench for xalu_mac: directed scenarios plus randomized ops
// against an arithmetic reference model of the unit.
module tb_xalu_mac;
   localparam int unsigned XLEN = 32;
   localparam int unsigned SEG  = 4;
   localparam int unsigned K    = 4;
   localparam int unsigned H    = XLEN / 2;
   localparam longint unsigned M = 64'hFFFF_FFFF;

   localparam logic [2:0] OP_ADD = 3'd0, OP_XADD = 3'd1, OP_MUL = 3'd2, OP_XMUL = 3'd3,
                          OP_MAC = 3'd4, OP_XMAC = 3'd5, OP_CLR = 3'd6, OP_RD = 3'd7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   longint unsigned acc_m;
   logic            sat_m;

   xalu_mac_if #(.XLEN(XLEN)) bus ();

   xalu_mac #(.XLEN(XLEN), .SEG_W(SEG), .DRUM_K(K)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic longint unsigned m_xadd(input longint unsigned a, input longint unsigned b);
      longint unsigned mask = (64'd1 << SEG) - 1;
      longint unsigned res = 0;
      longint unsigned cin;
      for (int i = 0; i < int'(XLEN / SEG); i++) begin
         cin = 0;
         if (i > 0)
            cin = (((a >> ((i-1)*SEG)) & mask) + ((b >> ((i-1)*SEG)) & mask)) >> SEG;
         res = res | (((((a >> (i*SEG)) & mask) + ((b >> (i*SEG)) & mask) + cin) & mask) << (i*SEG));
      end
      return res;
   endfunction

   function automatic void m_drum(input longint unsigned x, output longint unsigned xp, output int s);
      int p = 0;
      if (x < (64'd1 << K)) begin
         xp = x;
         s  = 0;
      end else begin
         while ((x >> (p + 1)) != 0) p++;
         s  = p - int'(K) + 1;
         xp = (x >> s) | 64'd1;
      end
   endfunction

   function automatic longint unsigned m_prod(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned ah = longint'(a) % (64'd1 << H);
      longint unsigned bh = longint'(b) % (64'd1 << H);
      longint unsigned ax, bx;
      int as, bs;
      if (op == OP_XMUL || op == OP_XMAC) begin
         m_drum(ah, ax, as);
         m_drum(bh, bx, bs);
         return (ax * bx) << (as + bs);
      end
      return ah * bh;
   endfunction

   function automatic int m_lat(input logic [2:0] op);
      if (op == OP_MUL || op == OP_MAC)   return 1 + int'(H);
      if (op == OP_XMUL || op == OP_XMAC) return 1 + int'(K);
      return 1;
   endfunction

   // Applies one op to the model accumulator and returns the expected result
   function automatic logic [31:0] m_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned r = 0;
      longint unsigned s;
      case (op)
         OP_ADD:  r = (longint'(a) + longint'(b)) & M;
         OP_XADD: r = m_xadd(longint'(a), longint'(b));
         OP_MUL, OP_XMUL: r = m_prod(op, a, b);
         OP_MAC, OP_XMAC: begin
            s = acc_m + m_prod(op, a, b);
            if (s > M) begin
               s = M;
               sat_m = 1'b1;
            end
            acc_m = s;
            r = s;
         end
         OP_CLR: begin
            r = acc_m;
            acc_m = 0;
            sat_m = 1'b0;
         end
         default: r = acc_m;
      endcase
      return 32'(r);
   endfunction

   // ---------------- drivers ----------------
   task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic sat, output int lat);
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.ready_i = 1'b0;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.result_o;
      sat = bus.sat_o;
   endtask

   task automatic consume();
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_during: got %b want 1", bus.ready_o); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      checks++;
      if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
      checks++;
      if (bus.sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", bus.sat_o); end
      acc_m = 0;
      sat_m = 1'b0;
   endtask

   task automatic test_add_wrap();
      logic [31:0] r; logic s; int lat;
      issue_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, r, s, lat);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL add_wrap: got %h want 00000000", r); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (bus.valid_o !== 1'b1 || bus.result_o !== 32'h0 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL add_hold: valid %b result %h ready %b want 1 00000000 0",
                     bus.valid_o, bus.result_o, bus.ready_o);
         end
      end
      consume();
   endtask

   task automatic test_xadd();
      logic [31:0] r; logic s; int lat;
      issue_op(OP_XADD, 32'h0000_00FF, 32'h0000_0001, r, s, lat);
      consume();
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL xadd_spec_err: got %h want 00000000", r); end
      issue_op(OP_XADD, 32'h12, 32'h21, r, s, lat);
      consume();
      checks++;
      if (r !== 32'h33) begin errors++; $display("FAIL xadd_simple: got %h want 00000033", r); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL xadd_latency: got %0d want 1", lat); end
   endtask

   task automatic test_mul();
      logic [31:0] r; logic s; int lat;
      issue_op(OP_MUL, 32'hFFFF, 32'hFFFF, r, s, lat);
      consume();
      checks++;
      if (r !== 32'hFFFE_0001) begin errors++; $display("FAIL mul_max: got %h want fffe0001", r); end
      checks++;
      if (lat != 17) begin errors++; $display("FAIL mul_latency: got %0d want 17", lat); end
      issue_op(OP_XMUL, 32'd1000, 32'd3, r, s, lat);
      consume();
      checks++;
      if (r !== 32'd2880) begin errors++; $display("FAIL xmul_1000x3: got %0d want 2880", r); end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL xmul_latency: got %0d want 5", lat); end
      issue_op(OP_XMUL, 32'd7, 32'd9, r, s, lat);
      consume();
      checks++;
      if (r !== 32'd63) begin errors++; $display("FAIL xmul_7x9: got %0d want 63", r); end
      issue_op(OP_MUL, 32'h0, 32'hFFFF, r, s, lat);
      consume();
      checks++;
      if (r !== 32'h0 || lat != 17) begin errors++; $display("FAIL mul_zero: got %h lat %0d want 0 lat 17", r, lat); end
   endtask

   task automatic test_sat_clear();
      logic [31:0] r; logic s; int lat;
      issue_op(OP_CLR, 32'h0, 32'h0, r, s, lat);
      consume();
      issue_op(OP_MAC, 32'hFFFF, 32'hFFFF, r, s, lat);
      consume();
      checks++;
      if (r !== 32'hFFFE_0001 || s !== 1'b0) begin errors++; $display("FAIL mac_first: got %h sat %b want fffe0001 sat 0", r, s); end
      issue_op(OP_MAC, 32'hFFFF, 32'hFFFF, r, s, lat);
      consume();
      checks++;
      if (r !== 32'hFFFF_FFFF || s !== 1'b1) begin errors++; $display("FAIL mac_saturate: got %h sat %b want ffffffff sat 1", r, s); end
      issue_op(OP_CLR, 32'h0, 32'h0, r, s, lat);
      consume();
      checks++;
      if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clr_old_acc: got %h want ffffffff", r); end
      issue_op(OP_RD, 32'h0, 32'h0, r, s, lat);
      consume();
      checks++;
      if (r !== 32'h0 || s !== 1'b0) begin errors++; $display("FAIL rdacc_after_clr: got %h sat %b want 0 sat 0", r, s); end
   endtask

   task automatic test_xmac();
      logic [31:0] r; logic s; int lat;
      issue_op(OP_CLR, 32'h0, 32'h0, r, s, lat);
      consume();
      issue_op(OP_XMAC, 32'd1000, 32'd3, r, s, lat);
      consume();
      checks++;
      if (r !== 32'd2880 || lat != 5) begin errors++; $display("FAIL xmac_first: got %0d lat %0d want 2880 lat 5", r, lat); end
      issue_op(OP_XMAC, 32'd1000, 32'd3, r, s, lat);
      consume();
      checks++;
      if (r !== 32'd5760) begin errors++; $display("FAIL xmac_second: got %0d want 5760", r); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r; logic s; int lat;
      bit seen = 1'b0;
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.op_i    = OP_MUL;
      bus.a_i     = 32'hFFFF;
      bus.b_i     = 32'hFFFF;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready_during: got %b want 1", bus.ready_o); end
      @(posedge clk); #1;
      rst = 1'b0;
      acc_m = 0;
      sat_m = 1'b0;
      checks++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.result_o !== 32'h0 || bus.sat_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: ready %b valid %b result %h sat %b want 1 0 0 0",
                  bus.ready_o, bus.valid_o, bus.result_o, bus.sat_o);
      end
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.valid_o === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL midrst_dropped: valid_o rose %b want 0", seen); end
      issue_op(OP_RD, 32'h0, 32'h0, r, s, lat);
      consume();
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL midrst_acc: got %h want 0", r); end
      issue_op(OP_ADD, 32'd2, 32'd3, r, s, lat);
      consume();
      checks++;
      if (r !== 32'd5 || lat != 1) begin errors++; $display("FAIL midrst_add: got %0d lat %0d want 5 lat 1", r, lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; logic s; int lat;
      int lat_m;
      // Inputs change while busy and valid_i stays high through consumption
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.op_i    = OP_MUL;
      bus.a_i     = 32'd3;
      bus.b_i     = 32'd5;
      bus.ready_i = 1'b0;
      @(posedge clk); #1;
      bus.op_i = OP_XADD;
      bus.a_i  = $urandom;
      bus.b_i  = $urandom;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
      checks++;
      if (bus.result_o !== 32'd15 || lat != 17) begin errors++; $display("FAIL stable_inputs: got %0d lat %0d want 15 lat 17", bus.result_o, lat); end
      bus.op_i    = OP_ADD;
      bus.a_i     = 32'd1;
      bus.b_i     = 32'd1;
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin errors++; $display("FAIL no_accept_on_consume: valid %b ready %b want 0 1", bus.valid_o, bus.ready_o); end
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      checks++;
      if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd2) begin errors++; $display("FAIL accept_after_consume: valid %b result %0d want 1 2", bus.valid_o, bus.result_o); end
      consume();
      for (int i = 0; i < 4; i++) begin
         logic [2:0] op = (i % 2 == 0) ? OP_XMUL : OP_ADD;
         logic [31:0] a = $urandom;
         logic [31:0] b = $urandom;
         logic [31:0] e = m_exec(op, a, b);
         lat_m = m_lat(op);
         issue_op(op, a, b, r, s, lat);
         consume();
         checks++;
         if (r !== e || lat != lat_m || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d: got %h lat %0d ready %b want %h lat %0d ready 1", i, r, lat, bus.ready_o, e, lat_m);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r, e, a, b; logic s; int lat, lat_m, hold;
      logic [2:0] op;
      issue_op(OP_CLR, 32'h0, 32'h0, r, s, lat);
      consume();
      acc_m = 0;
      sat_m = 1'b0;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
         e     = m_exec(op, a, b);
         lat_m = m_lat(op);
         issue_op(op, a, b, r, s, lat);
         checks++;
         if (r !== e || s !== sat_m || lat != lat_m) begin
            errors++;
            $display("FAIL rand_%0d op %0d a %h b %h: got %h sat %b lat %0d want %h sat %b lat %0d",
                     i, op, a, b, r, s, lat, e, sat_m, lat_m);
         end
         hold = $urandom_range(0, 2);
         for (int j = 0; j < hold; j++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.result_o !== e) begin
               errors++;
               $display("FAIL rand_hold_%0d: valid %b result %h want 1 %h", i, bus.valid_o, bus.result_o, e);
            end
         end
         consume();
      end
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.op_i    = 3'd0;
      bus.a_i     = 32'h0;
      bus.b_i     = 32'h0;
      test_reset();
      test_add_wrap();
      test_xadd();
      test_mul();
      test_sat_clear();
      test_xmac();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
